// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of a shared combinational ALU
//
// Purpose: accepts one operation at a time from requester 0 or 1, drives the
// shared ALU for one cycle, and holds the result for the owning requester
// until it is consumed.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op         - request handshake and operands (N = 0, 1)
//   rspN_valid/ready/result/zero/err- response handshake and payload (N = 0, 1)
//   alu_srcA/srcB/control           - drive to the shared ALU (0 outside EXEC)
//   alu_result/alu_zero             - returned from the shared ALU
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_zero,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_zero,
    output logic        rsp1_err,
    output logic [31:0] alu_srcA,
    output logic [31:0] alu_srcB,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;     // most recently granted requester
    logic             owner_q, owner_d;   // requester of the operation in flight
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0][31:0] res_q, res_d;
    logic [1:0]       zero_q, zero_d;
    logic [1:0]       err_q, err_d;

    logic grant;
    logic any_valid;
    logic op_legal;
    logic owner_rsp_ready;

    // On a tie the requester that did not win last time gets the grant.
    assign any_valid = req0_valid | req1_valid;
    assign grant     = (req0_valid & req1_valid) ? ~last_q : req1_valid;

    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101: op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
    end

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    // Ready is gated by reset so nothing looks accepted in a reset cycle.
    assign req0_ready = (state_q == S_IDLE) && any_valid && !grant && !reset;
    assign req1_ready = (state_q == S_IDLE) && any_valid &&  grant && !reset;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        res_d       = res_q;
        zero_d      = zero_q;
        err_d       = err_q;
        alu_srcA    = 32'd0;
        alu_srcB    = 32'd0;
        alu_control = 4'd0;

        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    a_d     = grant ? req1_a  : req0_a;
                    b_d     = grant ? req1_b  : req0_b;
                    op_d    = grant ? req1_op : req0_op;
                    owner_d = grant;
                    last_d  = grant;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_srcA             = a_q;
                alu_srcB             = b_q;
                alu_control          = op_q;
                res_d[owner_q]       = alu_result;
                zero_d[owner_q]      = alu_zero;
                err_d[owner_q]       = !op_legal;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = S_RESP;
            end
            S_RESP: begin
                if (owner_rsp_ready) begin
                    rsp_valid_d[owner_q] = 1'b0;
                    state_d              = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_q        <= 4'd0;
            rsp_valid_q <= 2'b00;
            res_q       <= '0;
            zero_q      <= 2'b00;
            err_q       <= 2'b00;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
        end
    end

    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp0_result = res_q[0];
    assign rsp1_result = res_q[1];
    assign rsp0_zero   = zero_q[0];
    assign rsp1_zero   = zero_q[1];
    assign rsp0_err    = err_q[0];
    assign rsp1_err    = err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [31:0] rsp0_result, rsp1_result;
    logic [31:0] alu_srcA, alu_srcB, alu_result;
    logic [3:0]  alu_control;
    logic        alu_zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // Shared ALU: ADD, SUB, AND, OR, SLL; anything else returns 0.
    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_srcA + alu_srcB;
            4'b0001: alu_result = alu_srcA - alu_srcB;
            4'b0010: alu_result = alu_srcA & alu_srcB;
            4'b0011: alu_result = alu_srcA | alu_srcB;
            4'b0101: alu_result = alu_srcA << alu_srcB[4:0];
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        req0_valid = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_req0_ready got=%b exp=0", req0_ready); end
        tick();
        #1;
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", {rsp0_valid, rsp1_valid}); end
        total++; if ({rsp0_result, rsp1_result} !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", {rsp0_result, rsp1_result}); end
        total++; if ({rsp0_zero, rsp0_err, rsp1_zero, rsp1_err} !== 4'd0) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {rsp0_zero, rsp0_err, rsp1_zero, rsp1_err}); end
        total++; if ({alu_srcA, alu_srcB, alu_control} !== 68'd0) begin bad++; $display("FAIL reset_alu_drive got=%h exp=0", {alu_srcA, alu_srcB, alu_control}); end
        req0_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_sub();
        do_reset();
        req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0001; req0_valid = 1'b1; rsp0_ready = 1'b1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL sub_grant got=%b exp=10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 1'b0;
        #1;
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL sub_exec_valid got=%b exp=0", rsp0_valid); end
        total++; if ({alu_srcA, alu_srcB, alu_control} !== {32'd5, 32'd3, 4'b0001}) begin bad++; $display("FAIL sub_alu_drive got=%h/%h/%h exp=5/3/1", alu_srcA, alu_srcB, alu_control); end
        tick();
        #1;
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin bad++; $display("FAIL sub_rsp_valid got=%b exp=10", {rsp0_valid, rsp1_valid}); end
        total++; if ({rsp0_result, rsp0_zero, rsp0_err} !== {32'd2, 1'b0, 1'b0}) begin bad++; $display("FAIL sub_rsp got=%0d z=%b e=%b exp=2 z=0 e=0", rsp0_result, rsp0_zero, rsp0_err); end
        total++; if ({alu_srcA, alu_control} !== 36'd0) begin bad++; $display("FAIL sub_alu_idle got=%h exp=0", {alu_srcA, alu_control}); end
        tick();
        #1;
        total++; if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL sub_consumed got=%b exp=0", rsp0_valid); end
    endtask

    task automatic test_tie_round_robin();
        do_reset();
        req0_a = 1; req0_b = 1; req0_op = 0; req1_a = 1; req1_b = 1; req1_op = 0;
        req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL tie_first_grant got=%b exp=10", {req0_ready, req1_ready}); end
        tick();
        req0_valid = 0;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL tie_exec_ready got=%b exp=00", {req0_ready, req1_ready}); end
        tick();
        #1;
        total++; if ({rsp0_valid, rsp1_valid, req1_ready} !== 3'b100) begin bad++; $display("FAIL tie_rsp0 got=%b exp=100", {rsp0_valid, rsp1_valid, req1_ready}); end
        tick();
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL tie_second_grant got=%b exp=01", {req0_ready, req1_ready}); end
        tick();
        req1_valid = 0;
        tick();
        #1;
        total++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin bad++; $display("FAIL tie_rsp1_valid got=%b exp=01", {rsp0_valid, rsp1_valid}); end
        total++; if (rsp1_result !== 32'd2) begin bad++; $display("FAIL tie_rsp1_result got=%0d exp=2", rsp1_result); end
        tick();
        req0_valid = 1; req1_valid = 1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL tie_third_grant got=%b exp=10", {req0_ready, req1_ready}); end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_sll();
        do_reset();
        req1_a = 32'd1; req1_b = 32'd33; req1_op = 4'b0101; req1_valid = 1; rsp1_ready = 1;
        tick();
        req1_valid = 0;
        tick();
        #1;
        total++; if ({rsp1_valid, rsp1_result, rsp1_zero, rsp1_err} !== {1'b1, 32'd2, 1'b0, 1'b0}) begin bad++; $display("FAIL sll_rsp got=v%b r=%0d z=%b e=%b exp=v1 r=2 z=0 e=0", rsp1_valid, rsp1_result, rsp1_zero, rsp1_err); end
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        req0_a = 32'd7; req0_b = 32'd9; req0_op = 4'b0100; req0_valid = 1; rsp0_ready = 1;
        tick();
        req0_valid = 0;
        tick();
        #1;
        total++; if ({rsp0_valid, rsp0_result, rsp0_zero, rsp0_err} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin bad++; $display("FAIL illegal_rsp got=v%b r=%0d z=%b e=%b exp=v1 r=0 z=1 e=1", rsp0_valid, rsp0_result, rsp0_zero, rsp0_err); end
        tick();
        req0_valid = 1;
        #1;
        total++; if ({rsp0_valid, req0_ready} !== 2'b01) begin bad++; $display("FAIL illegal_back_idle got=%b exp=01", {rsp0_valid, req0_ready}); end
        req0_valid = 0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_a = 32'd10; req0_b = 32'd4; req0_op = 4'b0000; req0_valid = 1; rsp0_ready = 0;
        tick();
        tick();
        req0_valid = 1; req1_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if ({rsp0_valid, rsp0_result} !== {1'b1, 32'd14}) begin bad++; $display("FAIL hold_rsp[%0d] got=v%b r=%0d exp=v1 r=14", i, rsp0_valid, rsp0_result); end
            total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL hold_ready[%0d] got=%b exp=00", i, {req0_ready, req1_ready}); end
            tick();
        end
        rsp0_ready = 1;
        #1;
        total++; if (rsp0_valid !== 1'b1) begin bad++; $display("FAIL hold_before_edge got=%b exp=1", rsp0_valid); end
        tick();
        #1;
        total++; if ({rsp0_valid, req0_ready, req1_ready} !== 3'b001) begin bad++; $display("FAIL hold_release got=%b exp=001", {rsp0_valid, req0_ready, req1_ready}); end
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic test_reset_in_exec();
        do_reset();
        req0_a = 32'd6; req0_b = 32'd2; req0_op = 4'b0000; req0_valid = 1; rsp0_ready = 1;
        tick();
        req0_valid = 0;
        reset = 1;
        tick();
        reset = 0;
        #1;
        total++; if ({rsp0_valid, rsp1_valid, req0_ready, req1_ready} !== 4'b0000) begin bad++; $display("FAIL abort_handshake got=%b exp=0000", {rsp0_valid, rsp1_valid, req0_ready, req1_ready}); end
        total++; if ({alu_srcA, alu_srcB, alu_control, rsp0_result} !== 100'd0) begin bad++; $display("FAIL abort_data got=%h exp=0", {alu_srcA, alu_srcB, alu_control, rsp0_result}); end
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin bad++; $display("FAIL abort_no_rsp[%0d] got=%b exp=00", i, {rsp0_valid, rsp1_valid}); end
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_tie_round_robin();
        test_sll();
        test_illegal();
        test_backpressure();
        test_reset_in_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
